// File: rtl/hit_input_conditioner.sv
// hit_input_conditioner
// Front end of the whack-a-mole score path: synchronizes and debounces the
// raw hit button, qualifies each clean press against the target window and
// accumulates qualified hits. The hit total is offered to the score-injection
// logic over a valid/ready handshake.

module hit_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             target_on,
  input  logic             score_ready,
  output logic             score_valid,
  output logic [CNT_W-1:0] score_inc,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic             btn_stable,
  output logic             saturated
);

  // The debounce counter counts up to DEBOUNCE_CYCLES-1 and never wraps.
  localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  // Debounce states: the stable level is 1 in UP/FILT_DN and 0 in DOWN/FILT_UP.
  localparam logic [1:0] ST_UP      = 2'd0;
  localparam logic [1:0] ST_FILT_DN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_FILT_UP = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   saturated_q, saturated_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic                   miss_pulse_q, miss_pulse_d;

  logic sync_out;
  logic stable_cur;
  logic press_fall;
  logic hit;
  logic transfer;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous button through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // Decode the current stable level from the debounce state.
  always_comb begin
    case (state_q)
      ST_UP, ST_FILT_DN: stable_cur = 1'b1;
      default:           stable_cur = 1'b0;
    endcase
  end

  // Debounce: a level change needs DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample abandons the filter and clears the count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    press_fall = 1'b0;
    if (sync_out == stable_cur) begin
      cnt_d   = '0;
      state_d = stable_cur ? ST_UP : ST_DOWN;
    end else if (cnt_q == DEB_LAST) begin
      cnt_d      = '0;
      state_d    = stable_cur ? ST_DOWN : ST_UP;
      press_fall = stable_cur;
    end else begin
      cnt_d   = cnt_q + DEB_W'(1);
      state_d = stable_cur ? ST_FILT_DN : ST_FILT_UP;
    end
  end

  // Classify each press as a hit or a miss using target_on at the press edge.
  always_comb begin
    hit          = press_fall & target_on;
    hit_pulse_d  = hit;
    miss_pulse_d = press_fall & ~target_on;
  end

  // Accumulate hits; a transfer empties the accumulator but keeps a hit that
  // lands on the same edge, and a hit arriving while full is dropped and
  // flagged.
  always_comb begin
    pending_d   = pending_q;
    saturated_d = saturated_q;
    transfer    = (pending_q != '0) && score_ready;
    if (transfer) begin
      pending_d = hit ? CNT_W'(1) : '0;
    end else if (hit) begin
      if (pending_q == PEND_MAX) begin
        saturated_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end
  end

  // Register all state with synchronous reset to the idle released condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '1;
      state_q      <= ST_UP;
      cnt_q        <= '0;
      pending_q    <= '0;
      saturated_q  <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      saturated_q  <= saturated_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

  assign score_valid = (pending_q != '0);
  assign score_inc   = pending_q;
  assign hit_pulse   = hit_pulse_q;
  assign miss_pulse  = miss_pulse_q;
  assign btn_stable  = stable_cur;
  assign saturated   = saturated_q;

endmodule

// File: tb/tb_hit_input_conditioner.sv
// tb_hit_input_conditioner
// Drives directed scenarios followed by randomized bouncy button traffic and
// compares every output each cycle against a behavioural model of the
// debounce window and the hit accumulator.

module tb_hit_input_conditioner;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int W    = 3;
  localparam int PMAX = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_raw;
  logic         target_on;
  logic         score_ready;
  logic         score_valid;
  logic [W-1:0] score_inc;
  logic         hit_pulse;
  logic         miss_pulse;
  logic         btn_stable;
  logic         saturated;

  int numCompared   = 0;
  int numMismatched = 0;

  // Model state: recent raw samples, stable level, hit total and flags.
  bit hist[$];
  bit mStable;
  int mPending;
  bit mSat;
  bit mHit;
  bit mMiss;
  int mConsumed   = 0;
  int dutConsumed = 0;
  int obsHits     = 0;
  int obsMisses   = 0;

  always #5 clk = ~clk;

  hit_input_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .target_on  (target_on),
    .score_ready(score_ready),
    .score_valid(score_valid),
    .score_inc  (score_inc),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .btn_stable (btn_stable),
    .saturated  (saturated)
  );

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge. The debouncer sees the raw level
  // from S edges ago; the level flips when the last D such samples all
  // disagree with it. After reset those samples read as released.
  task automatic modelEdge(input bit rst, input bit raw, input bit tgt, input bit rdy);
    bit flip;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < S + D; i++) hist.push_back(1'b1);
      mStable  = 1'b1;
      mPending = 0;
      mSat     = 1'b0;
      mHit     = 1'b0;
      mMiss    = 1'b0;
      return;
    end
    hist.push_back(raw);
    flip = 1'b1;
    for (int i = 1; i <= D; i++) begin
      if (hist[i] == mStable) flip = 1'b0;
    end
    void'(hist.pop_front());
    mHit  = 1'b0;
    mMiss = 1'b0;
    if (flip) begin
      if (mStable) begin
        if (tgt) mHit = 1'b1;
        else     mMiss = 1'b1;
      end
      mStable = !mStable;
    end
    if (mPending != 0 && rdy) begin
      mConsumed += mPending;
      mPending = mHit ? 1 : 0;
    end else if (mHit) begin
      if (mPending == PMAX) mSat = 1'b1;
      else                  mPending++;
    end
  endtask

  // Apply one cycle of inputs, step the model on the edge and compare
  // every output at the following falling edge.
  task automatic applyStimulus(input bit rst, input bit raw, input bit tgt, input bit rdy);
    if (score_valid === 1'b1 && rdy && !rst) dutConsumed += int'(score_inc);
    reset       = rst;
    btn_raw     = raw;
    target_on   = tgt;
    score_ready = rdy;
    @(posedge clk);
    modelEdge(rst, raw, tgt, rdy);
    @(negedge clk);
    checkOutput("hit_pulse",   hit_pulse,   32'(mHit));
    checkOutput("miss_pulse",  miss_pulse,  32'(mMiss));
    checkOutput("score_valid", score_valid, 32'(mPending != 0));
    checkOutput("score_inc",   score_inc,   32'(mPending));
    checkOutput("btn_stable",  btn_stable,  32'(mStable));
    checkOutput("saturated",   saturated,   32'(mSat));
    if (hit_pulse === 1'b1)  obsHits++;
    if (miss_pulse === 1'b1) obsMisses++;
  endtask

  // One clean press: held low long enough to register, then released.
  task automatic pressOnce(input bit tgt, input bit rdy);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b0, tgt, rdy);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, tgt, rdy);
  endtask

  initial begin
    int consumedBase;
    bit rawLvl;
    int segLeft;
    bit tgt;
    bit starve;

    reset       = 1'b1;
    btn_raw     = 1'b1;
    target_on   = 1'b0;
    score_ready = 1'b0;
    @(negedge clk);

    // Reset with the button released.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_stable", btn_stable, 1);
    checkOutput("rst_valid",  score_valid, 0);
    checkOutput("rst_inc",    score_inc, 0);

    // Reset arriving while the falling filter is counting.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    obsHits   = 0;
    obsMisses = 0;
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_mid_nopulse", obsHits + obsMisses, 0);

    // Clean hit: pulse exactly after edge 5, valid for one cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("lat_hit",   hit_pulse,   32'(k == 5));
      checkOutput("lat_valid", score_valid, 32'(k == 5));
    end
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

    // Bounce: 3 low, 1 high, then held low; single hit 5 edges after final fall.
    obsHits = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, (k == 3), 1'b1, 1'b1);
      checkOutput("bounce_hit", hit_pulse, 32'(k == 9));
    end
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("bounce_count", obsHits, 1);

    // Press outside the window.
    obsHits   = 0;
    obsMisses = 0;
    pressOnce(1'b0, 1'b1);
    checkOutput("miss_count", obsMisses, 1);
    checkOutput("miss_nohit", obsHits, 0);
    checkOutput("miss_valid", score_valid, 0);

    // Saturation with the consumer stalled.
    for (int p = 0; p < 9; p++) pressOnce(1'b1, 1'b0);
    checkOutput("sat_inc", score_inc, 7);
    checkOutput("sat_flag", saturated, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("sat_drain_valid", score_valid, 0);
    checkOutput("sat_sticky", saturated, 1);

    // Transfer on the same edge as a hit.
    consumedBase = dutConsumed;
    for (int p = 0; p < 3; p++) pressOnce(1'b1, 1'b0);
    checkOutput("pend3_inc", score_inc, 3);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b0, 1'b1, (k == 5));
    checkOutput("simul_inc", score_inc, 1);
    checkOutput("simul_valid", score_valid, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("simul_total", dutConsumed - consumedBase, 4);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

    // Randomized bouncy traffic with stall phases and occasional resets.
    rawLvl  = 1'b1;
    segLeft = 0;
    tgt     = 1'b1;
    starve  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (segLeft == 0) begin
        rawLvl  = !rawLvl;
        segLeft = $urandom_range(1, 9);
      end
      segLeft--;
      if ($urandom_range(0, 5) == 0) tgt = !tgt;
      if (c % 250 == 0) starve = ($urandom_range(0, 2) == 0);
      applyStimulus(($urandom_range(0, 399) == 0), rawLvl, tgt,
                    !starve && ($urandom_range(0, 3) != 0));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("consumed_total", dutConsumed, mConsumed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
